pattern_edit_ctrl: RTL

Sequences user edits into the shared pattern RAM of the tracker. Decodes new key presses into cursor moves and edit commands, holds the cursor over the 80x30 pattern grid, and runs read-modify-write cycles on the single-port pattern RAM. The playback sequencer shares that RAM with absolute priority. Sits between the USB keycode path and the pattern RAM; cursor outputs feed the VGA overlay.

---
 rtl/tracker_pkg.sv | 55 +++++
 rtl/key_press_decoder.sv | 47 ++++
 rtl/pattern_edit_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/tracker_pkg.sv
// Shared types and constants for the tracker pattern editor: keycodes, edit
// commands, cursor moves, edit FSM states and the cursor wrap helpers.
package tracker_pkg;

    localparam int DEF_COLS   = 80;
    localparam int DEF_ROWS   = 30;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 12;
    localparam int CURSOR_W   = 7;

    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_D = 8'h07;
    localparam logic [7:0] KEY_I = 8'h0C;
    localparam logic [7:0] KEY_K = 8'h0E;
    localparam logic [7:0] KEY_P = 8'h13;

    // Lookup order used by the decoder: moves first, then edit commands.
    localparam int NUM_KEYS = 7;
    localparam logic [7:0] KEY_TABLE [NUM_KEYS] = '{KEY_A, KEY_D, KEY_W, KEY_S, KEY_I, KEY_K, KEY_P};

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_INC,
        CMD_DEC,
        CMD_DEL
    } edit_cmd_t;

    typedef enum logic [2:0] {
        MV_NONE,
        MV_LEFT,
        MV_RIGHT,
        MV_UP,
        MV_DOWN
    } move_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        CAPT,
        WRITE
    } edit_state_t;

    function automatic logic [CURSOR_W-1:0] wrap_inc(input logic [CURSOR_W-1:0] pos,
                                                     input int unsigned limit);
        return (pos == CURSOR_W'(limit - 1)) ? '0 : pos + 1'b1;
    endfunction

    function automatic logic [CURSOR_W-1:0] wrap_dec(input logic [CURSOR_W-1:0] pos,
                                                     input int unsigned limit);
        return (pos == '0) ? CURSOR_W'(limit - 1) : pos - 1'b1;
    endfunction

endpackage

// File: rtl/key_press_decoder.sv
// Turns the raw USB keycode into single-shot move / edit-command strobes:
// a key only acts on the cycle it first differs from the previous keycode.
module key_press_decoder
    import tracker_pkg::*;
(
    input  logic      clk,
    input  logic      Reset_n,
    input  logic [7:0] keycode,
    output move_t     move,
    output edit_cmd_t cmd
);

    logic [7:0]          key_prev_reg;
    logic                press;
    logic [NUM_KEYS-1:0] hit;

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            key_prev_reg <= '0;
        end else begin
            key_prev_reg <= keycode;
        end
    end

    assign press = (keycode != 8'h00) && (keycode != key_prev_reg);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key_match
            assign hit[gi] = press && (keycode == KEY_TABLE[gi]);
        end
    endgenerate

    // Table entries are distinct, so at most one hit bit is set.
    always_comb begin
        move = MV_NONE;
        cmd  = CMD_NONE;
        if (hit[0]) move = MV_LEFT;
        if (hit[1]) move = MV_RIGHT;
        if (hit[2]) move = MV_UP;
        if (hit[3]) move = MV_DOWN;
        if (hit[4]) cmd  = CMD_INC;
        if (hit[5]) cmd  = CMD_DEC;
        if (hit[6]) cmd  = CMD_DEL;
    end

endmodule

// File: rtl/pattern_edit_ctrl.sv
// Pattern editor: keeps the cursor over the grid and runs read-modify-write
// edits on the single-port pattern RAM, yielding to playback on every cycle.
module pattern_edit_ctrl
    import tracker_pkg::*;
#(
    parameter int COLS   = DEF_COLS,
    parameter int ROWS   = DEF_ROWS,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              Reset_n,
    input  logic [7:0]        keycode,
    input  logic              play_req,
    input  logic [ADDR_W-1:0] play_addr,
    output logic              play_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [6:0]        cursor_x,
    output logic [6:0]        cursor_y,
    output logic              busy,
    output logic              edit_done
);

    move_t       move;
    edit_cmd_t   cmd;

    edit_state_t state_reg, state_next;
    logic [CURSOR_W-1:0] cursor_x_reg, cursor_x_next;
    logic [CURSOR_W-1:0] cursor_y_reg, cursor_y_next;
    edit_cmd_t           cmd_reg;
    logic [ADDR_W-1:0]   edit_addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [DATA_W-1:0]   capt_result;
    logic [ADDR_W-1:0]   cursor_addr;
    logic                accept;

    key_press_decoder u_decoder (
        .clk     (clk),
        .Reset_n (Reset_n),
        .keycode (keycode),
        .move    (move),
        .cmd     (cmd)
    );

    // ---------------- cursor ----------------
    always_comb begin
        cursor_x_next = cursor_x_reg;
        cursor_y_next = cursor_y_reg;
        case (move)
            MV_LEFT:  cursor_x_next = wrap_dec(cursor_x_reg, COLS);
            MV_RIGHT: cursor_x_next = wrap_inc(cursor_x_reg, COLS);
            MV_UP:    cursor_y_next = wrap_dec(cursor_y_reg, ROWS);
            MV_DOWN:  cursor_y_next = wrap_inc(cursor_y_reg, ROWS);
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cursor_x_reg <= '0;
            cursor_y_reg <= '0;
        end else begin
            cursor_x_reg <= cursor_x_next;
            cursor_y_reg <= cursor_y_next;
        end
    end

    assign cursor_x = cursor_x_reg;
    assign cursor_y = cursor_y_reg;

    // ---------------- edit datapath ----------------
    assign cursor_addr = ADDR_W'(cursor_y_reg) * ADDR_W'(COLS) + ADDR_W'(cursor_x_reg);
    assign accept      = (state_reg == IDLE) && (cmd != CMD_NONE);

    // Saturating update of the cell read back in CAPT.
    always_comb begin
        capt_result = mem_rdata;
        case (cmd_reg)
            CMD_INC: if (mem_rdata != '1) capt_result = mem_rdata + 1'b1;
            CMD_DEC: if (mem_rdata != '0) capt_result = mem_rdata - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cmd_reg       <= CMD_NONE;
            edit_addr_reg <= '0;
            wdata_reg     <= '0;
        end else if (accept) begin
            cmd_reg       <= cmd;
            edit_addr_reg <= cursor_addr;
            wdata_reg     <= '0;
        end else if (state_reg == CAPT) begin
            wdata_reg     <= capt_result;
        end
    end

    // ---------------- edit FSM ----------------
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (cmd == CMD_INC || cmd == CMD_DEC) state_next = READ;
                else if (cmd == CMD_DEL)              state_next = WRITE;
            end
            READ:    if (!play_req) state_next = CAPT;
            CAPT:    state_next = WRITE;
            WRITE:   if (!play_req) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Playback always wins the RAM port; the editor only drives it when free.
    always_comb begin
        play_gnt  = play_req;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        edit_done = 1'b0;
        busy      = (state_reg != IDLE);
        if (play_req) begin
            mem_addr = play_addr;
        end else begin
            case (state_reg)
                READ: mem_addr = edit_addr_reg;
                WRITE: begin
                    mem_addr  = edit_addr_reg;
                    mem_we    = 1'b1;
                    mem_wdata = wdata_reg;
                    edit_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
